// File: rtl/deskew_pkg.sv
// deskew_pkg: shared register map, STATUS bit positions and sequencer state encoding
package deskew_pkg;
  localparam logic [1:0] ADDR_IMG_DIM  = 2'd0;
  localparam logic [1:0] ADDR_IN_ADDR  = 2'd1;
  localparam logic [1:0] ADDR_OUT_ADDR = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OK      = 2;
  localparam int ST_ERR     = 3;
  localparam int ST_TIMEOUT = 4;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_CHK, S_RUN} state_e;
endpackage

// File: rtl/cfg_timeout_cnt.sv
// cfg_timeout_cnt: bounded wait counter for the config-check handshake
//   load_i   : restart the count at zero
//   en_i     : count one cycle of waiting
//   expire_o : high on the last permitted waiting cycle while en_i is high
module cfg_timeout_cnt #(
  parameter int CYCLES = 64,
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  logic [W-1:0] cnt_q;
  logic         at_max;
  assign at_max   = cnt_q == W'(CYCLES - 1);
  assign expire_o = en_i && at_max;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i && !at_max) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/deskew_cfg_regs.sv
// deskew_cfg_regs: host config registers and check/launch sequencer for the deskew core
//   host side : wr_en/wr_addr/wr_data writes, rd_en/rd_addr reads with rd_data/rd_valid one cycle later
//   core side : img_dim and image addresses held stable while busy, cfg_check_en request,
//               cfg_check_done/cfg_ok verdict, core_start launch, core_done completion, busy
module deskew_cfg_regs
  import deskew_pkg::*;
#(
  parameter int IMG_DIM_WIDTH  = 9,
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [1:0]               wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  input  logic [1:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [IMG_DIM_WIDTH-1:0] img_dim,
  output logic [ADDR_WIDTH-1:0]    in_img_start_addr,
  output logic [ADDR_WIDTH-1:0]    out_img_start_addr,
  output logic                     cfg_check_en,
  input  logic                     cfg_check_done,
  input  logic                     cfg_ok,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     busy
);
  state_e                   state_q, state_d;
  logic [IMG_DIM_WIDTH-1:0] img_dim_q;
  logic [ADDR_WIDTH-1:0]    in_addr_q, out_addr_q;
  logic                     done_q, ok_q, err_q, to_q;
  logic                     set_done, set_ok, set_err, set_to, clr;
  logic                     cfg_wr, start, expire;
  logic                     core_start_q, rd_valid_q;
  logic [31:0]              status, rd_mux, rd_data_q;
  logic                     unused_wr;
  assign unused_wr = ^wr_data;
  // Host writes only land while idle, so the core sees frozen values across check and run.
  assign cfg_wr = wr_en && state_q == S_IDLE;
  assign start  = cfg_wr && wr_addr == ADDR_CTRL && wr_data[0];
  cfg_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == S_REQ),
    .en_i     (state_q == S_WAIT_CHK),
    .expire_o (expire)
  );
  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    set_ok   = 1'b0;
    set_err  = 1'b0;
    set_to   = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr     = start;
        state_d = start ? S_REQ : S_IDLE;
      end
      S_REQ: state_d = S_WAIT_CHK;
      S_WAIT_CHK: begin
        // A verdict arriving on the expiry cycle takes priority over the timeout.
        if (cfg_check_done) begin
          state_d  = cfg_ok ? S_RUN : S_IDLE;
          set_ok   = cfg_ok;
          set_err  = !cfg_ok;
          set_done = !cfg_ok;
        end else if (expire) begin
          state_d  = S_IDLE;
          set_to   = 1'b1;
          set_done = 1'b1;
        end
      end
      S_RUN: begin
        state_d  = core_done ? S_IDLE : S_RUN;
        set_done = core_done;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Launch pulse only on the transition into RUN, not for the whole run.
      core_start_q <= state_q == S_WAIT_CHK && state_d == S_RUN;
      done_q       <= (done_q && !clr) || set_done;
      ok_q         <= (ok_q && !clr) || set_ok;
      err_q        <= (err_q && !clr) || set_err;
      to_q         <= (to_q && !clr) || set_to;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      img_dim_q  <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
    end else if (cfg_wr) begin
      if (wr_addr == ADDR_IMG_DIM) img_dim_q <= wr_data[IMG_DIM_WIDTH-1:0];
      if (wr_addr == ADDR_IN_ADDR) in_addr_q <= wr_data[ADDR_WIDTH-1:0];
      if (wr_addr == ADDR_OUT_ADDR) out_addr_q <= wr_data[ADDR_WIDTH-1:0];
    end
  end
  always_comb begin
    status              = '0;
    status[ST_BUSY]     = state_q != S_IDLE;
    status[ST_DONE]     = done_q;
    status[ST_OK]       = ok_q;
    status[ST_ERR]      = err_q;
    status[ST_TIMEOUT]  = to_q;
    rd_mux = rd_addr == ADDR_IMG_DIM  ? 32'(img_dim_q)  :
             rd_addr == ADDR_IN_ADDR  ? 32'(in_addr_q)  :
             rd_addr == ADDR_OUT_ADDR ? 32'(out_addr_q) : status;
  end
  // Reads sample pre-write register values, so a same-cycle write is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end
  assign rd_data            = rd_data_q;
  assign rd_valid           = rd_valid_q;
  assign img_dim            = img_dim_q;
  assign in_img_start_addr  = in_addr_q;
  assign out_img_start_addr = out_addr_q;
  assign cfg_check_en       = state_q == S_REQ;
  assign core_start         = core_start_q;
  assign busy               = state_q != S_IDLE;
endmodule

// File: tb/tb_deskew_cfg_regs.sv
// tb_deskew_cfg_regs: directed and randomized transaction checks for deskew_cfg_regs
module tb_deskew_cfg_regs;
  localparam int DW = 9;
  localparam int AW = 17;
  localparam int TO = 64;
  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, cfg_check_done, cfg_ok, core_done;
  logic [1:0]    wr_addr, rd_addr;
  logic [31:0]   wr_data, rd_data;
  logic          rd_valid, cfg_check_en, core_start, busy;
  logic [DW-1:0] img_dim;
  logic [AW-1:0] in_img_start_addr, out_img_start_addr;
  int            errors = 0;
  int            checks = 0;
  int            n_en = 0;
  int            n_start = 0;
  logic [31:0]   m_cfg [3];
  logic [31:0]   m_status;
  logic [31:0]   r;
  int            e0, s0;

  deskew_cfg_regs #(.IMG_DIM_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .img_dim(img_dim), .in_img_start_addr(in_img_start_addr),
    .out_img_start_addr(out_img_start_addr), .cfg_check_en(cfg_check_en),
    .cfg_check_done(cfg_check_done), .cfg_ok(cfg_ok), .core_start(core_start),
    .core_done(core_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (cfg_check_en) n_en++;
    if (core_start) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int a);
    return a == 0 ? 32'((64'd1 << DW) - 1) : 32'((64'd1 << AW) - 1);
  endfunction

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'd1);
    d = rd_data;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic cfg_wr(input int a, input logic [31:0] d);
    wr(2'(a), d);
    m_cfg[a] = d & mask(a);
  endtask

  task automatic check_cfg();
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      check($sformatf("cfg_read%0d", i), v, m_cfg[i]);
    end
    check("img_dim_out", 32'(img_dim), m_cfg[0]);
    check("in_addr_out", 32'(in_img_start_addr), m_cfg[1]);
    check("out_addr_out", 32'(out_img_start_addr), m_cfg[2]);
  endtask

  task automatic busy_tick();
    if ($urandom_range(1) == 1) wr(2'($urandom_range(3)), $urandom | 32'd1);
    else tick();
  endtask

  // kind: 0 checker accepts, 1 checker rejects, 2 checker stays silent
  task automatic do_op(input int kind, input int d, input int run_len);
    int ea, sa, cnt;
    logic [31:0] v;
    ea = n_en;
    sa = n_start;
    wr(2'd3, 32'd1);
    check("check_en_rise", 32'(cfg_check_en), 32'd1);
    check("busy_rise", 32'(busy), 32'd1);
    tick();
    check("check_en_single", 32'(cfg_check_en), 32'd0);
    if (kind == 2) begin
      cnt = 0;
      while (busy && cnt < 200) begin
        busy_tick();
        cnt++;
      end
      check("timeout_len", 32'(cnt), 32'(TO));
      m_status = 32'h12;
    end else begin
      if (d >= 2) begin
        rd(2'd3, v);
        check("status_waiting", v, 32'h01);
        repeat (d - 2) busy_tick();
      end
      cfg_check_done = 1'b1;
      cfg_ok = kind == 0;
      tick();
      cfg_check_done = 1'b0;
      cfg_ok = 1'($urandom_range(1));
      if (kind == 0) begin
        check("core_start_rise", 32'(core_start), 32'd1);
        check("busy_run", 32'(busy), 32'd1);
        rd(2'd3, v);
        check("status_running", v, 32'h05);
        check("core_start_single", 32'(core_start), 32'd0);
        wr(2'd0, 32'd32);
        wr(2'd3, 32'd1);
        repeat (run_len) busy_tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        m_status = 32'h06;
      end else begin
        check("busy_after_reject", 32'(busy), 32'd0);
        check("no_start_reject", 32'(core_start), 32'd0);
        m_status = 32'h0A;
      end
    end
    rd(2'd3, v);
    check("status_final", v, m_status);
    check("check_en_count", 32'(n_en - ea), 32'd1);
    check("core_start_count", 32'(n_start - sa), kind == 0 ? 32'd1 : 32'd0);
    check_cfg();
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    cfg_check_done = 1'b0;
    cfg_ok = 1'b0;
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) m_cfg[i] = '0;
    m_status = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_check_en", 32'(cfg_check_en), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd(2'd3, r);
    check("rst_status", r, 32'd0);
    check_cfg();

    cfg_wr(0, 32'd64);
    cfg_wr(1, 32'h0000);
    cfg_wr(2, 32'h2000);
    do_op(0, 3, 4);
    cfg_wr(0, 32'd64);
    do_op(1, 3, 0);
    do_op(2, 0, 0);
    do_op(0, 1, 0);
    do_op(1, TO, 0);
    do_op(0, TO, 2);

    // Strays outside their states must not disturb anything.
    core_done = 1'b1;
    cfg_check_done = 1'b1;
    cfg_ok = 1'b1;
    s0 = n_start;
    tick();
    core_done = 1'b0;
    cfg_check_done = 1'b0;
    repeat (2) tick();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_start", 32'(n_start - s0), 32'd0);
    rd(2'd3, r);
    check("stray_status", r, m_status);

    // Same-cycle write and read of one register returns the old value.
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 32'hFFFF_FFFF;
    rd_en = 1'b1;
    rd_addr = 2'd1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("rw_same_cycle", rd_data, m_cfg[1]);
    m_cfg[1] = mask(1);
    check_cfg();

    for (int k = 0; k < 6; k++) begin
      repeat (3) cfg_wr($urandom_range(2), $urandom);
      do_op($urandom_range(2), $urandom_range(1, 20), $urandom_range(0, 8));
    end

    // Reset while waiting for the checker abandons the operation.
    wr(2'd3, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    s0 = n_start;
    e0 = n_en;
    cfg_check_done = 1'b1;
    cfg_ok = 1'b1;
    tick();
    cfg_check_done = 1'b0;
    repeat (3) tick();
    check("rst_mid_no_start", 32'(n_start - s0), 32'd0);
    check("rst_mid_no_check_en", 32'(n_en - e0), 32'd0);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    rd(2'd3, r);
    check("rst_mid_status", r, 32'd0);
    for (int i = 0; i < 3; i++) m_cfg[i] = '0;
    check_cfg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
